// File: rtl/gt1_loader_if.sv
// Download-stream and RAM-write signals shared by the GT1 loader and its environment.
interface gt1_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        ioctl_wait;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic        ram_ack;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ram_ack,
    input  ioctl_wait, ram_addr, ram_data, ram_we
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, ram_ack,
    output ioctl_wait, ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/gt1_loader.sv
// GT1 file parser: turns the ioctl byte stream into acked Gigatron RAM writes, stalling the source via ioctl_wait per write.
// Define GT1_PAGE_CHECK_EN to reject segments whose offset+count would cross a 256-byte page.
module gt1_loader #(
  parameter logic [7:0] LOAD_INDEX = 8'd1
) (
  input  logic         clk_sys,
  input  logic         reset,
  gt1_loader_if.slave  bus,
  output logic [15:0]  start_addr,
  output logic         start_valid,
  output logic         busy,
  output logic         load_error
);

  typedef enum logic [3:0] {
    IDLE, HI, LO, SIZE, DATA, WRITE, STHI, STLO, DONE, ERR
  } state_t;

  state_t      state;
  logic        qual_d;
  logic        first_seg;
  logic [24:0] exp_addr;
  logic [7:0]  page;
  logic [7:0]  offset;
  logic [7:0]  st_hi;
  logic [8:0]  count;

  logic        qual;
  logic        accept;
  logic        addr_ok;
  logic [8:0]  size_cnt;

  assign qual     = bus.ioctl_download && (bus.ioctl_index == LOAD_INDEX);
  assign accept   = qual && bus.ioctl_wr && !bus.ioctl_wait;
  assign addr_ok  = (bus.ioctl_addr == exp_addr);
  assign size_cnt = (bus.ioctl_dout == 8'h00) ? 9'd256 : {1'b0, bus.ioctl_dout};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      qual_d         <= 1'b0;
      first_seg      <= 1'b0;
      exp_addr       <= '0;
      page           <= '0;
      offset         <= '0;
      st_hi          <= '0;
      count          <= '0;
      bus.ioctl_wait <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_data   <= '0;
      bus.ram_we     <= 1'b0;
      start_addr     <= '0;
      start_valid    <= 1'b0;
      busy           <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      qual_d      <= qual;
      start_valid <= 1'b0;
      // A new qualified download always restarts the parse, abandoning any prior one.
      if (qual && !qual_d) begin
        state          <= HI;
        busy           <= 1'b1;
        load_error     <= 1'b0;
        first_seg      <= 1'b1;
        exp_addr       <= '0;
        count          <= '0;
        bus.ram_we     <= 1'b0;
        bus.ioctl_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          HI, LO, SIZE, DATA, STHI, STLO: begin
            if (!qual) begin
              state      <= ERR;
              load_error <= 1'b1;
              busy       <= 1'b0;
            end else if (accept) begin
              exp_addr <= exp_addr + 25'd1;
              if (!addr_ok) begin
                state      <= ERR;
                load_error <= 1'b1;
                busy       <= 1'b0;
              end else begin
                case (state)
                  HI: begin
                    // Page 0x00 only terminates the segment list once a segment has been seen.
                    if (bus.ioctl_dout == 8'h00 && !first_seg) begin
                      state <= STHI;
                    end else begin
                      page  <= bus.ioctl_dout;
                      state <= LO;
                    end
                  end
                  LO: begin
                    offset <= bus.ioctl_dout;
                    state  <= SIZE;
                  end
                  SIZE: begin
`ifdef GT1_PAGE_CHECK_EN
                    if (({2'b00, offset} + {1'b0, size_cnt}) > 10'd256) begin
                      state      <= ERR;
                      load_error <= 1'b1;
                      busy       <= 1'b0;
                    end else
`endif
                    begin
                      count <= size_cnt;
                      state <= DATA;
                    end
                  end
                  DATA: begin
                    bus.ram_addr   <= {page, offset};
                    bus.ram_data   <= bus.ioctl_dout;
                    bus.ram_we     <= 1'b1;
                    bus.ioctl_wait <= 1'b1;
                    state          <= WRITE;
                  end
                  STHI: begin
                    st_hi <= bus.ioctl_dout;
                    state <= STLO;
                  end
                  STLO: begin
                    start_addr  <= {st_hi, bus.ioctl_dout};
                    start_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= DONE;
                  end
                  default: state <= ERR;
                endcase
              end
            end
          end
          WRITE: begin
            // The write in flight is always allowed to finish before reacting to a dropped download.
            if (bus.ram_ack) begin
              bus.ram_we     <= 1'b0;
              bus.ioctl_wait <= 1'b0;
              offset         <= offset + 8'd1;
              count          <= count - 9'd1;
              if (!qual) begin
                state      <= ERR;
                load_error <= 1'b1;
                busy       <= 1'b0;
              end else if (count == 9'd1) begin
                first_seg <= 1'b0;
                state     <= HI;
              end else begin
                state <= DATA;
              end
            end
          end
          DONE, ERR: begin
            if (!bus.ioctl_download) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gt1_loader.sv
// Directed bench for gt1_loader: GT1 streams with a delayed-ack RAM model and a write log.
module tb_gt1_loader;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] start_addr;
  logic        start_valid;
  logic        busy;
  logic        load_error;

  always #5 clk_sys = ~clk_sys;

  gt1_loader_if bus ();

  gt1_loader #(.LOAD_INDEX(8'd1)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .bus         (bus.slave),
    .start_addr  (start_addr),
    .start_valid (start_valid),
    .busy        (busy),
    .load_error  (load_error)
  );

  int checks = 0;
  int errors = 0;
  int ack_dly = 0;
  int sv_cnt = 0;
  int foff = 0;
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM model: acks ack_dly cycles after ram_we, checks the request holds still meanwhile.
  initial begin
    int cnt;
    logic [15:0] a0;
    logic [7:0]  d0;
    cnt = 0;
    a0 = '0;
    d0 = '0;
    bus.ram_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      bus.ram_ack = 1'b0;
      if (!bus.ram_we) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          a0 = bus.ram_addr;
          d0 = bus.ram_data;
        end else begin
          chk("we_addr_stable", bus.ram_addr, a0);
          chk("we_data_stable", bus.ram_data, d0);
          chk("we_wait_high", bus.ioctl_wait, 1'b1);
        end
        if (cnt >= ack_dly) begin
          bus.ram_ack = 1'b1;
          log_addr.push_back(bus.ram_addr);
          log_data.push_back(bus.ram_data);
        end else begin
          cnt++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_sys);
    if (start_valid) sv_cnt++;
  end

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk_sys);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    while (bus.ioctl_wait && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 500) chk("wait_timeout", n, 0);
    @(posedge clk_sys);
    #1 bus.ioctl_wr = 1'b0;
  endtask

  task automatic put(input logic [7:0] d);
    send_byte(25'(foff), d);
    foff++;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk_sys);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    foff = 0;
    log_addr.delete();
    log_data.delete();
    sv_cnt = 0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl();
    repeat (2) @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    int bad;
    logic [7:0] o;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.ioctl_index    = 8'd1;

    // Reset state
    #1;
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_wait", bus.ioctl_wait, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", load_error, 1'b0);
    chk("rst_start", start_addr, 16'h0000);
    chk("rst_sv", start_valid, 1'b0);
    @(negedge clk_sys);
    reset = 1'b0;

    // Basic file: one 3-byte segment at 0x0200, start 0x0200
    ack_dly = 2;
    start_dl(8'd1);
    chk("basic_busy_on", busy, 1'b1);
    put(8'h02); put(8'h00); put(8'h03);
    put(8'hAA); put(8'hBB); put(8'hCC);
    put(8'h00); put(8'h02); put(8'h00);
    repeat (3) @(negedge clk_sys);
    chk("basic_nwr", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("basic_a0", log_addr[0], 16'h0200); chk("basic_d0", log_data[0], 8'hAA);
      chk("basic_a1", log_addr[1], 16'h0201); chk("basic_d1", log_data[1], 8'hBB);
      chk("basic_a2", log_addr[2], 16'h0202); chk("basic_d2", log_data[2], 8'hCC);
    end
    chk("basic_start", start_addr, 16'h0200);
    chk("basic_sv", sv_cnt, 1);
    chk("basic_err", load_error, 1'b0);
    chk("basic_busy_off", busy, 1'b0);
    end_dl();

    // 256-byte segment starting at offset 0x30
    ack_dly = 0;
    start_dl(8'd1);
    put(8'h00); put(8'h30); put(8'h00);
    for (int k = 0; k < 256; k++) put(8'(k));
`ifdef GT1_PAGE_CHECK_EN
    repeat (3) @(negedge clk_sys);
    chk("pgchk_nwr", log_addr.size(), 0);
    chk("pgchk_err", load_error, 1'b1);
    chk("pgchk_busy", busy, 1'b0);
`else
    put(8'h00); put(8'h00); put(8'h30);
    repeat (3) @(negedge clk_sys);
    chk("wrap_nwr", log_addr.size(), 256);
    if (log_addr.size() == 256) begin
      bad = 0;
      for (int k = 0; k < 256; k++) begin
        o = 8'h30 + 8'(k);
        if (log_addr[k] !== {8'h00, o} || log_data[k] !== 8'(k)) bad++;
      end
      chk("wrap_bad_writes", bad, 0);
      chk("wrap_first", log_addr[0], 16'h0030);
      chk("wrap_at_208", log_addr[208], 16'h0000);
      chk("wrap_last", log_addr[255], 16'h002F);
    end
    chk("wrap_start", start_addr, 16'h0030);
    chk("wrap_err", load_error, 1'b0);
`endif
    end_dl();

    // Slow RAM: ack after 20 cycles
    ack_dly = 20;
    start_dl(8'd1);
    put(8'h10); put(8'h00); put(8'h02); put(8'h11); put(8'h22);
    put(8'h00); put(8'h10); put(8'h00);
    repeat (3) @(negedge clk_sys);
    chk("slow_nwr", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("slow_a0", log_addr[0], 16'h1000); chk("slow_d0", log_data[0], 8'h11);
      chk("slow_a1", log_addr[1], 16'h1001); chk("slow_d1", log_data[1], 8'h22);
    end
    chk("slow_start", start_addr, 16'h1000);
    chk("slow_sv", sv_cnt, 1);
    end_dl();

    // Download drops after 5 of 10 data bytes
    ack_dly = 2;
    start_dl(8'd1);
    put(8'h20); put(8'h00); put(8'h0A);
    for (int k = 0; k < 5; k++) put(8'h40 + 8'(k));
    bus.ioctl_download = 1'b0;
    repeat (12) @(negedge clk_sys);
    chk("drop_nwr", log_addr.size(), 5);
    chk("drop_err", load_error, 1'b1);
    chk("drop_busy", busy, 1'b0);
    chk("drop_sv", sv_cnt, 0);
    chk("drop_start_kept", start_addr, 16'h1000);

    // Out-of-sequence byte address
    start_dl(8'd1);
    chk("restart_err_clr", load_error, 1'b0);
    put(8'h50);
    send_byte(25'd5, 8'h00);
    repeat (2) @(negedge clk_sys);
    chk("seq_err", load_error, 1'b1);
    chk("seq_busy", busy, 1'b0);
    end_dl();

    // Reset in the middle of a write, then a clean load
    ack_dly = 50;
    start_dl(8'd1);
    put(8'h30); put(8'h00); put(8'h01); put(8'h55);
    repeat (3) @(negedge clk_sys);
    chk("midwr_we", bus.ram_we, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_we", bus.ram_we, 1'b0);
    chk("arst_wait", bus.ioctl_wait, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_start", start_addr, 16'h0000);
    chk("arst_raddr", bus.ram_addr, 16'h0000);
    chk("arst_rdata", bus.ram_data, 8'h00);
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    ack_dly = 1;
    start_dl(8'd1);
    put(8'h40); put(8'h00); put(8'h01); put(8'h77);
    put(8'h00); put(8'h40); put(8'h00);
    repeat (3) @(negedge clk_sys);
    chk("post_rst_nwr", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      chk("post_rst_a0", log_addr[0], 16'h4000);
      chk("post_rst_d0", log_data[0], 8'h77);
    end
    chk("post_rst_start", start_addr, 16'h4000);
    chk("post_rst_sv", sv_cnt, 1);
    end_dl();

    // Foreign index is ignored
    start_dl(8'd0);
    for (int k = 0; k < 4; k++) begin
      put(8'h12);
      chk("idx0_wait", bus.ioctl_wait, 1'b0);
    end
    chk("idx0_busy", busy, 1'b0);
    chk("idx0_we", bus.ram_we, 1'b0);
    chk("idx0_nwr", log_addr.size(), 0);
    end_dl();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gt1_loader.md
GT1_LOADER -- requirements
Module: gt1_loader

Interface
REQ-001 Parameter LOAD_INDEX, default 8'd1, ioctl_index value whose downloads this block parses.
REQ-002 clk_sys  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ioctl_download  input  1  high for the duration of a file transfer.
REQ-005 ioctl_wr  input  1  byte strobe; byte accepted when ioctl_wr=1 and ioctl_wait=0.
REQ-006 ioctl_addr  input  25  file byte offset of ioctl_dout.
REQ-007 ioctl_dout  input  8  file byte.
REQ-008 ioctl_index  input  8  file type selector.
REQ-009 ioctl_wait  output  1  backpressure to the download source.
REQ-010 ram_addr  output  16  Gigatron RAM write address.
REQ-011 ram_data  output  8  Gigatron RAM write data.
REQ-012 ram_we  output  1  write request, held until acknowledged.
REQ-013 ram_ack  input  1  RAM write completion, one-cycle pulse or level.
REQ-014 start_addr  output  16  GT1 execution start address.
REQ-015 start_valid  output  1  one-cycle pulse when start_addr is updated.
REQ-016 busy  output  1  parse in progress.
REQ-017 load_error  output  1  sticky error flag, cleared at next download start.

Function
REQ-018 The block SHALL parse only while ioctl_download=1 and ioctl_index==LOAD_INDEX; other downloads SHALL be ignored, with ioctl_wait=0.
REQ-019 A rising edge of the qualified download SHALL enter state HI, set busy=1 and clear load_error, also when a parse is already active (restart).
REQ-020 States: IDLE, HI, LO, SIZE, DATA, WRITE, STHI, STLO, DONE, ERR.
REQ-021 HI: an accepted byte of 0x00 after the first segment -> STHI; otherwise latch page -> LO. A first-segment byte of 0x00 is a zero-page address.
REQ-022 LO: latch offset -> SIZE; SIZE: latch count, with 0x00 meaning 256 (9-bit counter) -> DATA.
REQ-023 DATA: an accepted byte drives ram_addr={page,offset} and ram_data=byte, sets ram_we=1 and ioctl_wait=1 in the next cycle -> WRITE.
REQ-024 WRITE: ram_we, ram_addr and ram_data SHALL stay stable until ram_ack=1 is sampled; then ram_we=0 and ioctl_wait=0 in the next cycle, offset increments mod 256 (page unchanged) and the count decrements; count 0 -> HI, else -> DATA.
REQ-025 STHI/STLO: latch start high/low; after STLO, start_addr updates and start_valid pulses for exactly 1 cycle -> DONE; busy=0.
REQ-026 The fall of ioctl_download in any state other than IDLE/DONE/ERR SHALL set load_error=1 -> ERR, busy=0; a pending WRITE SHALL first complete its ack.
REQ-027 An accepted byte whose ioctl_addr differs from the expected sequential offset SHALL set load_error -> ERR.
REQ-028 DONE/ERR SHALL ignore further bytes with ioctl_wait=0 and return to IDLE when ioctl_download=0.
REQ-029 ioctl_wait SHALL be 1 only in WRITE and in the DATA-to-WRITE transition cycle.

Reset
REQ-030 Reset SHALL force state IDLE, ram_we=0, ioctl_wait=0, busy=0, load_error=0, start_valid=0, start_addr=16'h0000, ram_addr=0, ram_data=0, and all counters 0, immediately and regardless of the clock.
REQ-031 Reset during WRITE SHALL drop ram_we without waiting for ram_ack.

Configuration
REQ-032 Macro GT1_PAGE_CHECK_EN defined: a segment with offset+count>256 SHALL set load_error at SIZE -> ERR, with no RAM writes for that segment.
REQ-033 Macro GT1_PAGE_CHECK_EN undefined: no check; the offset wraps within the page per REQ-024.

Verification
REQ-034 File 02 00 03 AA BB CC 00 02 00 with ram_ack 2 cycles after ram_we -> writes 0x0200=AA, 0x0201=BB, 0x0202=CC; start_addr=0x0200; start_valid 1 pulse; load_error=0.
REQ-035 Segment 00 30 00 followed by 256 bytes -> 256 writes 0x0030..0x00FF and then 0x0000..0x002F without GT1_PAGE_CHECK_EN; load_error=1 and 0 writes with the macro.
REQ-036 ram_ack held low for 20 cycles -> ram_we, ram_addr and ram_data stable and ioctl_wait=1 throughout; no byte is lost.
REQ-037 ioctl_download drops after 5 bytes of a 10-byte segment -> load_error=1, busy=0, no start_valid.
REQ-038 Reset asserted mid-WRITE -> all outputs at their reset values asynchronously; a new download then loads correctly.
REQ-039 A download with ioctl_index=0 -> no ram_we, ioctl_wait=0, busy=0.
